// File: rtl/io_bank_pkg.sv
// Shared definitions for the staggered embedded-IO bank: FSM states and the
// positions of the per-channel configuration bits within a channel's chain segment.
package io_bank_pkg;

  typedef enum logic [1:0] {
    ISOL    = 2'd0,
    RELEASE = 2'd1,
    ACTIVE  = 2'd2
  } bank_state_t;

  localparam int CFG_DIR_BIT = 0;
  localparam int CFG_INV_BIT = 1;

endpackage

// File: rtl/io_bank_channel.sv
// One pad channel: gates pad direction, core->pad data and pad->core data
// behind the channel's release enable and its two configuration bits.
module io_bank_channel
  import io_bank_pkg::*;
(
  input  logic       en,
  input  logic [1:0] cfg,
  input  logic       soc_in,
  input  logic       outpad,
  output logic       dir,
  output logic       out,
  output logic       inpad
);

  logic dir_cfg;
  logic inv_cfg;

  assign dir_cfg = cfg[CFG_DIR_BIT];
  assign inv_cfg = cfg[CFG_INV_BIT];

  // A channel that is not yet released keeps its output driver off.
  assign dir   = ~en | dir_cfg;
  assign out   = en & ~dir_cfg & outpad;
  assign inpad = en & dir_cfg & (soc_in ^ inv_cfg);

endmodule

// File: rtl/grid_io_bank_staggered.sv
// Embedded-IO bank with its own config-chain segment and a staggered release
// from isolation, one channel every STAGGER cycles.
module grid_io_bank_staggered
  import io_bank_pkg::*;
#(
  parameter int NUM_IO   = 8,
  parameter int STAGGER  = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset_N,
  input  logic              IO_ISOL_N,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_loaded,
  output logic              release_done,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad
);

  localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
  localparam int SHIFT_W   = $clog2(CHAIN_LEN + 2);
  localparam int REL_W     = $clog2(NUM_IO * STAGGER + 1);

  logic [CHAIN_LEN-1:0] chain;
  logic [SHIFT_W-1:0]   shift_cnt;
  logic [NUM_IO-1:0]    en_mask;
  logic [REL_W-1:0]     rel_cnt;
  bank_state_t          state;

  // shift_cnt sticks one past a full load so any over-shift is remembered until reset.
  always_ff @(posedge prog_clk) begin
    if (!pReset_N) begin
      chain     <= '0;
      shift_cnt <= '0;
    end else if (ccff_en) begin
      chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      if (shift_cnt != SHIFT_W'(CHAIN_LEN + 1))
        shift_cnt <= shift_cnt + SHIFT_W'(1);
    end
  end

  assign ccff_tail    = chain[CHAIN_LEN-1];
  assign cfg_loaded   = (shift_cnt == SHIFT_W'(CHAIN_LEN));
  assign release_done = (state == ACTIVE);

  always_ff @(posedge prog_clk) begin
    if (!pReset_N) begin
      state   <= ISOL;
      en_mask <= '0;
      rel_cnt <= '0;
    end else if (!IO_ISOL_N || ccff_en) begin
      state   <= ISOL;
      en_mask <= '0;
      rel_cnt <= '0;
    end else begin
      case (state)
        ISOL: begin
          en_mask <= '0;
          rel_cnt <= '0;
          if (cfg_loaded)
            state <= RELEASE;
        end
        RELEASE: begin
          rel_cnt <= rel_cnt + REL_W'(1);
          for (int k = 0; k < NUM_IO; k++) begin
            if (rel_cnt == REL_W'(k * STAGGER))
              en_mask[k] <= 1'b1;
          end
          if (rel_cnt == REL_W'((NUM_IO - 1) * STAGGER))
            state <= ACTIVE;
        end
        ACTIVE: begin
          state <= ACTIVE;
        end
        default: begin
          state   <= ISOL;
          en_mask <= '0;
          rel_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar ch = 0; ch < NUM_IO; ch++) begin : g_ch
    io_bank_channel u_channel (
      .en     (en_mask[ch]),
      .cfg    (chain[ch*CFG_BITS +: 2]),
      .soc_in (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[ch]),
      .outpad (io_outpad[ch]),
      .dir    (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[ch]),
      .out    (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[ch]),
      .inpad  (io_inpad[ch])
    );
  end

endmodule

// File: tb/tb_grid_io_bank_staggered.sv
// Scoreboard bench for grid_io_bank_staggered: a driver issues cycles and queues the
// expected observation from a behavioural model; a monitor pops and compares each cycle.
module tb_grid_io_bank_staggered;

  localparam int N = 8;
  localparam int S = 4;
  localparam int L = 2 * N;

  logic         clk;
  logic         pReset_N;
  logic         IO_ISOL_N;
  logic         ccff_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic         cfg_loaded;
  logic         release_done;
  logic [N-1:0] soc_in;
  logic [N-1:0] soc_out;
  logic [N-1:0] soc_dir;
  logic [N-1:0] io_outpad;
  logic [N-1:0] io_inpad;

  typedef struct packed {
    logic [N-1:0] dir;
    logic [N-1:0] out;
    logic [N-1:0] inpad;
    logic         tail;
    logic         loaded;
    logic         done;
  } obs_t;

  obs_t exp_q[$];
  int   pass_count = 0;
  int   check_count = 0;

  // Model state: chain as a queue (index 0 nearest the head), shifts seen since
  // reset, and how many edges the bank has spent releasing.
  bit   cfg_q[$];
  int   shifts;
  bit   releasing;
  int   rel_edges;

  grid_io_bank_staggered #(.NUM_IO(N), .STAGGER(S), .CFG_BITS(2)) dut (
    .prog_clk                         (clk),
    .pReset_N                         (pReset_N),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_en                          (ccff_en),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .cfg_loaded                       (cfg_loaded),
    .release_done                     (release_done),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (soc_dir),
    .io_outpad                        (io_outpad),
    .io_inpad                         (io_inpad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one rising edge with the given inputs.
  task automatic modelStep(input logic rst_n, input logic isol_n, input logic shift, input logic head);
    if (!rst_n) begin
      cfg_q = {};
      for (int i = 0; i < L; i++) cfg_q.push_back(1'b0);
      shifts    = 0;
      releasing = 1'b0;
      rel_edges = 0;
    end else begin
      if (shift) begin
        cfg_q.push_front(head);
        void'(cfg_q.pop_back());
        if (shifts <= L) shifts++;
      end
      if (!isol_n || shift) begin
        releasing = 1'b0;
        rel_edges = 0;
      end else if (releasing) begin
        if (rel_edges < 1000) rel_edges++;
      end else if (shifts == L) begin
        releasing = 1'b1;
        rel_edges = 0;
      end
    end
  endtask

  // Channel k is live once k*S+1 release edges have elapsed.
  function automatic obs_t modelExpect(input logic [N-1:0] pad_in, input logic [N-1:0] fab_out);
    obs_t e;
    bit   en_k;
    bit   d;
    bit   inv;
    for (int k = 0; k < N; k++) begin
      en_k       = releasing && (rel_edges >= k * S + 1);
      d          = cfg_q[2*k];
      inv        = cfg_q[2*k+1];
      e.dir[k]   = !en_k || d;
      e.out[k]   = en_k && !d && fab_out[k];
      e.inpad[k] = en_k && d && (pad_in[k] ^ inv);
    end
    e.tail   = cfg_q[L-1];
    e.loaded = (shifts == L);
    e.done   = releasing && (rel_edges >= (N - 1) * S + 1);
    return e;
  endfunction

  // Drive one cycle at the falling edge and queue what the DUT should show after the next rising edge.
  task automatic applyStimulus(input logic rst_n, input logic isol_n, input logic shift, input logic head);
    @(negedge clk);
    pReset_N  = rst_n;
    IO_ISOL_N = isol_n;
    ccff_en   = shift;
    ccff_head = head;
    soc_in    = N'($urandom);
    io_outpad = N'($urandom);
    modelStep(rst_n, isol_n, shift, head);
    exp_q.push_back(modelExpect(soc_in, io_outpad));
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = '{dir: soc_dir, out: soc_out, inpad: io_inpad, tail: ccff_tail,
          loaded: cfg_loaded, done: release_done};
    check_count++;
    if (a === e) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL obs t=%0t dir=%h/%h out=%h/%h inpad=%h/%h tail=%b/%b loaded=%b/%b done=%b/%b (actual/required)",
               $time, a.dir, e.dir, a.out, e.out, a.inpad, e.inpad, a.tail, e.tail,
               a.loaded, e.loaded, a.done, e.done);
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // The first bit shifted ends up at the far end of the chain, so send the MSB first.
  task automatic loadCfg(input logic [L-1:0] v);
    for (int i = L - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, 1'b1, v[i]);
  endtask

  task automatic runIdle(input int n, input logic isol_n);
    repeat (n) applyStimulus(1'b1, isol_n, 1'b0, 1'($urandom));
  endtask

  // Monitor: the DUT presents a full observation every cycle, sampled 1ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    pReset_N  = 1'b0;
    IO_ISOL_N = 1'b0;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    soc_in    = '0;
    io_outpad = '0;
    for (int i = 0; i < L; i++) cfg_q.push_back(1'b0);
    shifts    = 0;
    releasing = 1'b0;
    rel_edges = 0;

    // All-input load, full staggered release.
    doReset(2);
    loadCfg(16'h5555);
    runIdle(35, 1'b1);

    // All-output, then all-input inverted.
    doReset(2);
    loadCfg(16'h0000);
    runIdle(35, 1'b1);
    doReset(2);
    loadCfg(16'hFFFF);
    runIdle(35, 1'b1);

    // Isolation drop part-way through the release, then restart.
    doReset(2);
    loadCfg(16'h5555);
    runIdle(11, 1'b1);
    runIdle(1, 1'b0);
    runIdle(35, 1'b1);

    // Over-shift by one bit: no release allowed.
    doReset(2);
    loadCfg(16'hA5C3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    runIdle(15, 1'b1);

    // Shift pulse while active forces isolation.
    doReset(2);
    loadCfg(L'($urandom));
    runIdle(32, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'($urandom));
    runIdle(10, 1'b1);

    // Reset in the middle of a release.
    doReset(2);
    loadCfg(L'($urandom));
    runIdle(12, 1'b1);
    doReset(1);
    runIdle(5, 1'b1);

    // Long random shift stream to watch the tail replay the head.
    doReset(2);
    repeat (40) applyStimulus(1'b1, 1'($urandom), 1'b1, 1'($urandom));

    // Randomised traffic around a valid load.
    for (int r = 0; r < 4; r++) begin
      doReset(2);
      loadCfg(L'($urandom));
      repeat (150)
        applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
                      $urandom_range(0, 29) == 0, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check_count++;
    if (exp_q.size() == 0) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
